cla_nibble_serial_ctrl: RTL
===========================

Name: cla_nibble_serial_ctrl

Overview:
- Sequencer that adds WIDTH-bit operands over multiple clocks by time-sharing one 4-bit carry-lookahead slice, one nibble per cycle, LSB nibble first.
- Carry is registered between nibbles. Valid/ready handshakes on input and output.
- Sits between a requester (ALU issue logic or test harness) and the bit_4_cla slice. Trades latency for area in the FPGA build.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  controller can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in for bit 0
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  two's-complement overflow
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset: all of the following are 0 on the first edge with rst=1: state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0, sum=0, cout=0, ovf=0, busy=0, counter=0, carry register=0.
- rst dominates every other input, including mid-RUN and mid-DONE. An in-flight operation is discarded with no partial output.

FSM states:
- IDLE: in_ready=1. On in_valid=1 at an edge:
  - latch a and b into shift registers op_a/op_b
  - carry_r<=cin, cnt<=0
  - latch a[WIDTH-1] and b[WIDTH-1]
  - go to RUN
- RUN: in_ready=0, busy=1. Each edge:
  - drive the slice with op_a[3:0], op_b[3:0], carry_r
  - shift the slice's 4-bit sum into the top of the result shift register (result >> 4)
  - op_a and op_b shift right 4; carry_r<=slice cout; cnt<=cnt+1
  - when cnt==NIBBLES-1: go to DONE and load sum, cout, ovf
- DONE: out_valid=1, busy=1. sum, cout and ovf are stable.
  - On out_ready=1 at an edge: out_valid<=0, go to IDLE.
  - in_valid is ignored while DONE.

Latency and throughput:
- If accept happens at edge E0, out_valid is high after edge E0+NIBBLES (4 cycles for WIDTH=16).
- With out_ready and in_valid held high, one result completes every NIBBLES+2 cycles.
- No input accept in the same cycle as output handshake: in_ready rises the cycle after DONE→IDLE.

Arithmetic:
- Result is (a+b+cin) mod 2^WIDTH. cout is the carry out of bit WIDTH-1.
- ovf = (a_msb==b_msb) && (sum[WIDTH-1]!=a_msb).

Output holding and boundaries:
- sum, cout and ovf hold their last values after the handshake, until the next DONE load. Consumers must qualify them with out_valid.
- Counter wraps only via the DONE transition; it is never compared beyond NIBBLES-1.
- Operands changing on a/b after accept have no effect.

Decomposition:
- Shared package/include holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 decodes to IDLE
  - the NIBBLE_W=4 constant
  - the counter-width function clog2(NIBBLES)
- One sub-module: the existing bit_4_cla slice, instantiated once, purely combinational, in the RUN datapath.
- Shift registers, FSM, counter and output registers are local.

Test Plan (WIDTH=16):
- Carry through every nibble: a=0xFFFF, b=0x0001, cin=0 → after 4 cycles out_valid=1, sum=0x0000, cout=1, ovf=0.
- Carry-in propagation: a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. Second case a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Output backpressure: out_ready=0 for 5 cycles after out_valid:
  - out_valid stays 1 and sum stays stable
  - in_ready stays 0 and a new in_valid is not accepted
  - raise out_ready → IDLE next cycle
- Reset mid-operation: rst=1 on the 2nd RUN cycle → next cycle out_valid=0, in_ready=1, busy=0, sum=0. A fresh a=0x0003, b=0x0004 then yields sum=0x0007.
- Back-to-back throughput: in_valid and out_ready tied 1 with three operand pairs → out_valid pulses spaced exactly 6 cycles apart, results in order.

Source files
------------

// File: rtl/cla_nibble_serial_ctrl_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder controller.
// Holds the FSM encoding, slice width and counter sizing helper.
package cla_nibble_serial_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    // Encoding 2'd3 is never produced and is decoded as IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/cla_nibble_serial_ctrl_bit_4_cla.sv
// Purely combinational 4-bit carry-lookahead adder slice.
// Carries are computed from generate/propagate terms, not rippled.
module bit_4_cla
    import cla_nibble_serial_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[NIBBLE_W-1:0];
    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/cla_nibble_serial_ctrl.sv
// Adds WIDTH-bit operands one nibble per cycle through a single shared
// 4-bit CLA slice, LSB nibble first, with valid/ready on both sides.
module cla_nibble_serial_ctrl
    import cla_nibble_serial_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W   = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    state_t state;
    state_t state_n;

    logic             accept_c;
    logic             step_c;
    logic             last_c;
    logic             release_c;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry_r;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    bit_4_cla u_slice (
        .a    (op_a[NIBBLE_W-1:0]),
        .b    (op_b[NIBBLE_W-1:0]),
        .cin  (carry_r),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus the datapath strobes; in_ready and busy decode state directly
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        accept_c  = 1'b0;
        step_c    = 1'b0;
        last_c    = 1'b0;
        release_c = 1'b0;
        case (state)
            RUN: begin
                busy   = 1'b1;
                step_c = 1'b1;
                if (cnt == CNT_LAST) begin
                    last_c  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                busy = 1'b1;
                if (out_ready) begin
                    release_c = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_n  = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    // Operand shifters, carry, nibble counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            carry_r   <= 1'b0;
            cnt       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept_c) begin
                op_a    <= a;
                op_b    <= b;
                carry_r <= cin;
                cnt     <= '0;
                a_msb   <= a[WIDTH-1];
                b_msb   <= b[WIDTH-1];
            end
            if (step_c) begin
                op_a    <= {{NIBBLE_W{1'b0}}, op_a[WIDTH-1:NIBBLE_W]};
                op_b    <= {{NIBBLE_W{1'b0}}, op_b[WIDTH-1:NIBBLE_W]};
                res     <= {slice_sum, res[WIDTH-1:NIBBLE_W]};
                carry_r <= slice_cout;
                cnt     <= cnt + CNT_W'(1);
            end
            // Final nibble lands straight in the output register
            if (last_c) begin
                sum       <= {slice_sum, res[WIDTH-1:NIBBLE_W]};
                cout      <= slice_cout;
                ovf       <= (a_msb == b_msb) && (slice_sum[NIBBLE_W-1] != a_msb);
                out_valid <= 1'b1;
                cnt       <= '0;
            end
            if (release_c) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
